// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core's fetch stage: the word type, the next-PC
// mode encoding and the default return-address-stack depth.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        PC_NEXT = 3'd0,
        PC_BR   = 3'd1,
        PC_J    = 3'd2,
        PC_JR   = 3'd3,
        PC_JAL  = 3'd4,
        PC_RET  = 3'd5
    } pcsrc_t;

    localparam int RAS_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored, and the occupancy saturates at DEPTH.
module ras_stack
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  push,
    input  logic  pop,
    input  word_t din,
    output word_t top,
    output logic  empty,
    output logic  full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    word_t           mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    assign empty = (count_q == CW'(0));
    assign full  = (count_q == CW'(DEPTH));
    // The newest entry sits just below the write pointer; wraps naturally.
    assign top   = mem_q[wr_ptr_q - PW'(1)];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (full) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_d = wr_ptr_q - PW'(1);
            count_d  = count_q - CW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC mux, PC register, sticky halt and a
// one-cycle pulse when a RAS-predicted return disagrees with the register value.
module pc_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT   = 32'h0000_0000,
    parameter int    RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_en,
    input  logic        halt,
    input  logic [2:0]  pc_src,
    input  word_t       imm16,
    input  logic [25:0] imm26,
    input  word_t       jr_addr,
    output word_t       imemaddr,
    output word_t       pc_plus4,
    output logic        halted,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        ras_mispredict
);

    word_t pc_q, pc_d;
    logic  halted_q, halted_d;
    logic  mis_q, mis_d;
    word_t target_s;
    word_t ras_top_s;
    logic  update_s, push_s, pop_s;

    assign imemaddr       = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign halted         = halted_q;
    assign ras_mispredict = mis_q;
    assign update_s       = pc_en & ~halt & ~halted_q;

    ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push_s),
        .pop   (pop_s),
        .din   (pc_plus4),
        .top   (ras_top_s),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // Next-PC selection and RAS/halt/mispredict control.
    always_comb begin
        target_s = pc_plus4;
        pc_d     = pc_q;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        mis_d    = 1'b0;
        halted_d = halted_q | (pc_en & halt);
        case (pc_src)
            PC_NEXT: target_s = pc_plus4;
            PC_BR:   target_s = pc_plus4 + (imm16 << 2);
            PC_J:    target_s = {pc_plus4[31:28], imm26, 2'b00};
            PC_JR:   target_s = jr_addr;
            PC_JAL:  target_s = {pc_plus4[31:28], imm26, 2'b00};
            PC_RET:  target_s = ras_empty ? jr_addr : ras_top_s;
            default: target_s = pc_plus4;
        endcase
        if (update_s) begin
            pc_d   = target_s;
            push_s = (pc_src == PC_JAL);
            pop_s  = (pc_src == PC_RET) && !ras_empty;
            mis_d  = pop_s && (ras_top_s != jr_addr);
        end else begin
            pc_d   = pc_q;
            push_s = 1'b0;
            pop_s  = 1'b0;
            mis_d  = 1'b0;
        end
    end

    // PC, halt and mispredict registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= PC_INIT;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
        end
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the pipelined MIPS core's fetch stage. It generalises the earlier fixed PC with:
- a configurable reset vector;
- a full next-PC mode set: sequential, branch, jump, jump-register, jump-and-link, return;
- a circular return-address stack (RAS) of configurable depth;
- a sticky halt.

`imemaddr` feeds instruction memory directly. Control inputs come from the decode/hazard logic.

## Interface
Parameters:
- `PC_INIT`, default 32'h0000_0000: value loaded into `imemaddr` on reset.
- `RAS_DEPTH`, default 4: RAS entries; power of two, minimum 2.

Ports (`word_t` is 32 bits, from `cpu_types_pkg`):
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `pc_en` in 1: advance enable; low means hold (stall).
- `halt` in 1: halt request from decode.
- `pc_src` in 3 (`pcsrc_t`): next-PC mode.
- `imm16` in 32 (`word_t`): already sign-extended branch offset, in words.
- `imm26` in 26: jump target field.
- `jr_addr` in 32 (`word_t`): register-file value for JR/RET.
- `imemaddr` out 32 (`word_t`): current PC, registered.
- `pc_plus4` out 32 (`word_t`): `imemaddr + 4`, combinational; the link value.
- `halted` out 1: sticky halt status, registered.
- `ras_empty` out 1: RAS occupancy is 0.
- `ras_full` out 1: RAS occupancy is `RAS_DEPTH`.
- `ras_mispredict` out 1: one-cycle registered pulse on a RET whose popped value differs from `jr_addr`.

## Operation
- An update happens on an edge when `pc_en & ~halt & ~halted`. Otherwise `imemaddr`, the RAS and its pointers all hold.
- `pc_src` encodings and resulting next PC:
  - `PC_NEXT` (0): `pc_plus4`.
  - `PC_BR` (1): `pc_plus4 + (imm16 << 2)`.
  - `PC_J` (2): `{pc_plus4[31:28], imm26, 2'b00}`.
  - `PC_JR` (3): `jr_addr`.
  - `PC_JAL` (4): same target as `PC_J`, plus push `pc_plus4` onto the RAS.
  - `PC_RET` (5): if RAS non-empty, pop and use the top entry; if empty, use `jr_addr` with no pop.
  - 6, 7: treated as `PC_NEXT`.
- All arithmetic is 32-bit modulo 2^32 and wraps silently, e.g. 32'hFFFF_FFFC + 4 = 0.
- RAS is circular:
  - Push when full overwrites the oldest entry; the write pointer wraps; occupancy saturates at `RAS_DEPTH`.
  - Pop when empty is not performed.
  - Pointers wrap modulo `RAS_DEPTH`.
- Halt:
  - `halt` asserted together with `pc_en` sets `halted`.
  - `halt` blocks the update in that same cycle, regardless of `pc_src`.
  - `halted` is cleared only by `RST`.
- `ras_mispredict` is set on the edge of an executed RET-with-pop when `top != jr_addr`. It clears on the next edge.

## Timing
- Reset values: `imemaddr = PC_INIT`, `halted = 0`, RAS occupancy 0 (so `ras_empty = 1`, `ras_full = 0`), `ras_mispredict = 0`. RAS entry contents are don't-care.
- Reset has priority over every other input.
- Reset asserted mid-sequence (RAS partly full, or `halted` set) fully restores the reset values above on the next edge.
- Latency is 1 cycle: the next PC computed from the inputs sampled at edge N appears on `imemaddr` after edge N.
- `pc_plus4` follows `imemaddr` with zero latency.
- The `pc_src` mux, `ras_empty` and `ras_full` are combinational within the cycle.
- A JAL immediately followed by a RET in back-to-back cycles pops the just-pushed value. No bypass is needed because the push lands on the first edge.
- `pc_en` low during a JAL or RET cycle: no push or pop happens; the instruction is re-presented later.

## Structure
- `cpu_types_pkg` gains:
  - `typedef enum logic [2:0] pcsrc_t` holding `PC_NEXT` through `PC_RET`;
  - `RAS_DEPTH_DEFAULT`.
- `pc_if` is extended with `jr_addr`, `pc_plus4`, `halted` and the `ras_*` signals, in modports `pc` and `tb`.
- One sub-module, `ras_stack`:
  - parameter `DEPTH`;
  - inputs: `push`, `pop`, `din`;
  - outputs: `top`, `empty`, `full`;
  - implements the circular overwrite behaviour.
- `pc_unit` contains the next-PC mux, the PC register, the halt flop and the mispredict flop.

## Test plan
- Reset with `PC_INIT = 32'h0000_0100`, then 3 cycles of `PC_NEXT` with `pc_en = 1` → `imemaddr` reads 0x100, 0x104, 0x108, 0x10C.
- At PC 0x200, `PC_BR` with `imm16 = 32'hFFFF_FFFE` → next PC 0x1FC. At PC 0x1000_0000, `PC_J` with `imm26 = 26'h0000040` → next PC 0x1000_0100.
- At PC 0x300: JAL, then JAL at 0x500, then RET with `jr_addr = 0x504`, then RET with `jr_addr = 0x999` → PCs go to 0x504 then 0x304, and `ras_mispredict` pulses once, after the second RET.
- `RAS_DEPTH = 4`: push 5 times with link values A..E, then pop 5 times (`jr_addr = 0x40`) → pops return E, D, C, B; the 5th RET finds the RAS empty and goes to 0x40; `ras_full` is high after the 4th push.
- `pc_en = 0` for 2 cycles during RET → PC and occupancy unchanged. `halt = 1` with `PC_J` → PC frozen and `halted = 1` for 10 cycles.
- `RST` asserted while `halted = 1` and occupancy = 3 → next cycle `imemaddr = PC_INIT`, `halted = 0`, `ras_empty = 1`.
